uart_frame_rx: RTL and testbench

Oversampled UART receiver that deserializes LEN consecutive 8N1 bytes into one parallel frame word and flags completion with a single-cycle strobe. It sits directly upstream of the RTMQ UART configuration path. Its frame word and strobe drive the config-instruction/override-flag latch. It adds false-start rejection, framing-error detection and an inter-byte timeout, so a corrupted or truncated frame never reaches the config latch.

---
 rtl/uart_frame_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_frame_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - oversampled 8N1 UART receiver assembling LEN bytes into one frame word
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   in   - asynchronous UART Rx line, idle high
//   str  - last complete frame; first byte in the top 8 bits, last byte in [7:0]
//   recv - one-cycle pulse, new frame valid on str
//   err  - one-cycle pulse, framing error or inter-byte timeout (partial frame dropped)
module uart_frame_rx #(
  parameter int LEN      = 5,
  parameter int BAUD     = 100,
  parameter int TMO_BITS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic [8*LEN-1:0] str,
  output logic             recv,
  output logic             err
);

  localparam int FW  = 8 * LEN;
  localparam int BW  = $clog2(BAUD);
  localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int TMO = TMO_BITS * BAUD;
  localparam int TW  = $clog2(TMO + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_rxs_d;
  logic [BW-1:0]   r_baud_cnt;
  logic [2:0]      r_bit_cnt;
  logic [CW-1:0]   r_byte_cnt;
  logic [TW-1:0]   r_tmo_cnt;
  logic [7:0]      r_shift;
  logic [FW-1:0]   r_asm;
  logic [FW-1:0]   r_str;
  logic            r_recv;
  logic            r_err;

  logic            w_fall;
  logic            w_tick;
  logic [FW-1:0]   w_asm_next;

  assign str  = r_str;
  assign recv = r_recv;
  assign err  = r_err;

  // r_sync2 is the synchronized line (rxs); r_rxs_d is its one-cycle delay for edge detect.
  assign w_fall     = r_rxs_d & ~r_sync2;
  assign w_tick     = (r_baud_cnt == '0);
  // Earlier bytes move toward the MSB end as later bytes arrive.
  assign w_asm_next = (r_asm << 8) | FW'(r_shift);

  // Synchronizer resets to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_shift    <= '0;
      r_asm      <= '0;
      r_str      <= '0;
      r_recv     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_recv <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            // Count down to the middle of the start bit.
            r_state    <= S_START;
            r_baud_cnt <= BW'(BAUD / 2 - 1);
          end else if (r_byte_cnt != '0) begin
            // Inter-byte timeout only matters once a frame is partly assembled.
            if (r_tmo_cnt == '0) begin
              r_err      <= 1'b1;
              r_byte_cnt <= '0;
              r_asm      <= '0;
            end else begin
              r_tmo_cnt <= r_tmo_cnt - 1'b1;
            end
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!r_sync2) begin
              r_state    <= S_DATA;
              r_baud_cnt <= BW'(BAUD - 1);
              r_bit_cnt  <= '0;
            end else begin
              // Glitch shorter than half a bit: silently ignore.
              r_state <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift    <= {r_sync2, r_shift[7:1]};
            r_baud_cnt <= BW'(BAUD - 1);
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_sync2) begin
              // Leave at mid stop bit so a start bit right after it is not missed.
              r_state   <= S_IDLE;
              r_tmo_cnt <= TW'(TMO - 1);
              if (r_byte_cnt == CW'(LEN - 1)) begin
                r_str      <= w_asm_next;
                r_recv     <= 1'b1;
                r_byte_cnt <= '0;
                r_asm      <= '0;
              end else begin
                r_asm      <= w_asm_next;
                r_byte_cnt <= r_byte_cnt + 1'b1;
              end
            end else begin
              r_err      <= 1'b1;
              r_byte_cnt <= '0;
              r_asm      <= '0;
              r_state    <= S_BREAK;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end
        S_BREAK: begin
          // A line held low reports once, then waits for idle.
          if (r_sync2) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - randomized self-checking bench for uart_frame_rx
//
// Two instances: dut_a (LEN=2, BAUD=16, TMO_BITS=20) for the functional scenarios and
// dut_b (LEN=5, BAUD=100) for sender baud-rate skew.
module tb_uart_frame_rx;

  localparam int LA = 2;
  localparam int BA = 16;
  localparam int TA = 20;
  localparam int LB = 5;
  localparam int BB = 100;
  localparam int TB = 20;

  // Cycles from the in falling edge of a byte to its recv/err-from-stop pulse.
  localparam longint LAT_A = 2 + BA / 2 + 9 * BA + 1;

  logic            clk  = 1'b0;
  logic            rst  = 1'b1;
  logic            in_a = 1'b1;
  logic            in_b = 1'b1;
  logic [8*LA-1:0] str_a;
  logic            recv_a;
  logic            err_a;
  logic [8*LB-1:0] str_b;
  logic            recv_b;
  logic            err_b;

  uart_frame_rx #(.LEN(LA), .BAUD(BA), .TMO_BITS(TA)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .str(str_a), .recv(recv_a), .err(err_a)
  );

  uart_frame_rx #(.LEN(LB), .BAUD(BB), .TMO_BITS(TB)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .str(str_b), .recv(recv_b), .err(err_b)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  int              recv_cnt_a = 0;
  int              err_cnt_a  = 0;
  int              recv_cnt_b = 0;
  int              err_cnt_b  = 0;
  int              both_cnt   = 0;
  longint          recv_cyc_a = 0;
  longint          err_cyc_a  = 0;
  logic [8*LA-1:0] cap_a      = '0;
  logic [8*LB-1:0] cap_b      = '0;

  always @(negedge clk) begin
    if (recv_a) begin
      recv_cnt_a <= recv_cnt_a + 1;
      recv_cyc_a <= cyc;
      cap_a      <= str_a;
    end
    if (err_a) begin
      err_cnt_a <= err_cnt_a + 1;
      err_cyc_a <= cyc;
    end
    if (recv_b) begin
      recv_cnt_b <= recv_cnt_b + 1;
      cap_b      <= str_b;
    end
    if (err_b) err_cnt_b <= err_cnt_b + 1;
    if ((recv_a && err_a) || (recv_b && err_b)) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a frame word is the received bytes concatenated, first byte most significant.
  function automatic logic [63:0] frame_of(input logic [7:0] q[$]);
    logic [63:0] w;
    w = '0;
    foreach (q[i]) w = (w << 8) | 64'(q[i]);
    return w;
  endfunction

  task automatic drive(input bit sel, input bit v, input int n);
    if (sel) in_b = v;
    else     in_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input int per,
                           input bit stop_v, output longint t_start);
    t_start = cyc;
    drive(sel, 1'b0, per);
    for (int k = 0; k < 8; k++) drive(sel, b[k], per);
    drive(sel, stop_v, per);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] q[$], input int per,
                            input int gap_max, output longint t_last);
    foreach (q[i]) begin
      send_byte(sel, q[i], per, 1'b1, t_last);
      if (i < q.size() - 1) drive(sel, 1'b1, per * $urandom_range(gap_max, 0));
    end
    drive(sel, 1'b1, 2 * per);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [63:0] exp_a;
    longint      t;
    int          r0;
    int          e0;
    int          per;

    repeat (3) @(negedge clk);
    chk("rst_str", 64'(str_a), 64'h0);
    chk("rst_recv", 64'(recv_a), 64'h0);
    chk("rst_err", 64'(err_a), 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back two-byte frame plus latency.
    q = '{8'hA5, 8'h3C};
    r0 = recv_cnt_a; e0 = err_cnt_a;
    send_frame(1'b0, q, BA, 0, t);
    exp_a = frame_of(q);
    chk("b2b_recv", 64'(recv_cnt_a - r0), 64'd1);
    chk("b2b_str", 64'(cap_a), exp_a);
    chk("b2b_err", 64'(err_cnt_a - e0), 64'd0);
    chk("b2b_lat", 64'(recv_cyc_a - t), 64'(LAT_A));

    // False start: short low pulse.
    r0 = recv_cnt_a; e0 = err_cnt_a;
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 3 * BA);
    chk("fs_recv", 64'(recv_cnt_a - r0), 64'd0);
    chk("fs_err", 64'(err_cnt_a - e0), 64'd0);
    chk("fs_hold", 64'(str_a), exp_a);
    q = '{8'h12, 8'h34};
    send_frame(1'b0, q, BA, 1, t);
    exp_a = frame_of(q);
    chk("fs_str", 64'(cap_a), exp_a);
    chk("fs_recv2", 64'(recv_cnt_a - r0), 64'd1);

    // Framing error on the first byte, then a good frame.
    r0 = recv_cnt_a; e0 = err_cnt_a;
    send_byte(1'b0, 8'h55, BA, 1'b0, t);
    drive(1'b0, 1'b1, 2 * BA);
    chk("fe_err", 64'(err_cnt_a - e0), 64'd1);
    chk("fe_errlat", 64'(err_cyc_a - t), 64'(LAT_A));
    chk("fe_recv", 64'(recv_cnt_a - r0), 64'd0);
    chk("fe_hold", 64'(str_a), exp_a);
    q = '{8'hBE, 8'hEF};
    send_frame(1'b0, q, BA, 0, t);
    exp_a = frame_of(q);
    chk("fe_str", 64'(cap_a), exp_a);
    chk("fe_recv2", 64'(recv_cnt_a - r0), 64'd1);
    chk("fe_err2", 64'(err_cnt_a - e0), 64'd1);

    // Inter-byte timeout after a lone byte.
    r0 = recv_cnt_a; e0 = err_cnt_a;
    send_byte(1'b0, 8'h11, BA, 1'b1, t);
    drive(1'b0, 1'b1, 400 - BA);
    chk("tmo_err", 64'(err_cnt_a - e0), 64'd1);
    chk("tmo_time", 64'(err_cyc_a - t), 64'(LAT_A + TA * BA));
    chk("tmo_recv", 64'(recv_cnt_a - r0), 64'd0);
    chk("tmo_hold", 64'(str_a), exp_a);
    q = '{8'($urandom_range(255, 0)), 8'($urandom_range(255, 0))};
    send_frame(1'b0, q, BA, 2, t);
    exp_a = frame_of(q);
    chk("tmo_str", 64'(cap_a), exp_a);

    // Reset mid data bit 3 of the second byte.
    b1 = 8'($urandom_range(255, 0));
    b2 = 8'($urandom_range(255, 0)) | 8'h08;
    r0 = recv_cnt_a; e0 = err_cnt_a;
    send_byte(1'b0, b1, BA, 1'b1, t);
    drive(1'b0, 1'b0, BA);
    for (int k = 0; k < 3; k++) drive(1'b0, b2[k], BA);
    drive(1'b0, b2[3], BA / 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mr_str", 64'(str_a), 64'h0);
    chk("mr_recv", 64'(recv_a), 64'h0);
    chk("mr_err", 64'(err_a), 64'h0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 3 * BA);
    chk("mr_nostrobe", 64'(recv_cnt_a - r0 + err_cnt_a - e0), 64'd0);
    chk("mr_str2", 64'(str_a), 64'h0);
    q = '{8'h0F, 8'h0F};
    send_frame(1'b0, q, BA, 0, t);
    chk("mr_after", 64'(cap_a), frame_of(q));

    // Random frames with random inter-byte gaps (zero gap included).
    for (int n = 0; n < 8; n++) begin
      q.delete();
      for (int i = 0; i < LA; i++) q.push_back(8'($urandom_range(255, 0)));
      r0 = recv_cnt_a; e0 = err_cnt_a;
      send_frame(1'b0, q, BA, 2, t);
      chk($sformatf("rnd%0d_str", n), 64'(cap_a), frame_of(q));
      chk($sformatf("rnd%0d_cnt", n), 64'(recv_cnt_a - r0 + 2 * (err_cnt_a - e0)), 64'd1);
    end

    // Sender baud skew on the 5-byte instance: +4 %, -4 %, then random within band.
    for (int n = 0; n < 3; n++) begin
      per = (n == 0) ? 104 : (n == 1) ? 96 : $urandom_range(104, 96);
      if (n < 2) q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
      else begin
        q.delete();
        for (int i = 0; i < LB; i++) q.push_back(8'($urandom_range(255, 0)));
      end
      r0 = recv_cnt_b; e0 = err_cnt_b;
      send_frame(1'b1, q, per, 0, t);
      chk($sformatf("skew%0d_str", n), 64'(cap_b), frame_of(q));
      chk($sformatf("skew%0d_recv", n), 64'(recv_cnt_b - r0), 64'd1);
      chk($sformatf("skew%0d_err", n), 64'(err_cnt_b - e0), 64'd0);
    end

    chk("recv_err_overlap", 64'(both_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
